// File: rtl/uart_core.sv
`timescale 1ns/1ps
// uart_core: 8N1 UART transmitter + receiver with exported baud ticks.
//   sys_clk, rst_n          : clock, asynchronous active-low reset
//   tx_clk, rx_clk          : TX bit tick (every TX_DIV), RX 16x tick (every RX_DIV)
//   tx_en, tx_data          : send request and byte, captured when idle
//   tx, tx_busy             : serial out (idle high), transmitter occupied
//   rx                      : asynchronous serial in
//   rx_data, rx_ready       : last good byte, sticky new-byte flag
//   rx_ready_clear          : clears rx_ready (a same-cycle set wins)
module uart_core #(
    parameter int CLK_FREQ = 30_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    output logic       tx_clk,
    output logic       rx_clk,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ready_clear
);
    localparam int TX_DIV = CLK_FREQ / BAUD;
    localparam int RX_DIV = CLK_FREQ / (16 * BAUD);
    localparam int TXW = $clog2(TX_DIV + 1);
    localparam int RXW = $clog2(RX_DIV + 1);
    localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RXW-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]     tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [2:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic           tx_q, tx_d, tx_busy_q, tx_busy_d;
    logic [1:0]     rx_sync_q, rx_sync_d;
    logic [3:0]     rx_tick_q, rx_tick_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_ready_q, rx_ready_d;
    logic           rx_line;

    assign tx_clk   = tx_cnt_q == TX_LAST;
    assign rx_clk   = rx_cnt_q == RX_LAST;
    assign rx_line  = rx_sync_q[1];
    assign tx       = tx_q;
    assign tx_busy  = tx_busy_q;
    assign rx_data  = rx_data_q;
    assign rx_ready = rx_ready_q;

    // tx/tx_busy are registered from the state, so they trail it by one cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_clk ? '0 : tx_cnt_q + TXW'(1);
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_state_q == START ? 1'b0 : tx_state_q == DATA ? tx_shift_q[0] : 1'b1;
        tx_busy_d  = tx_state_q != IDLE;
        case (tx_state_q)
            IDLE: if (tx_en) begin
                tx_state_d = START;
                tx_cnt_d   = '0;
                tx_shift_d = tx_data;
                tx_bit_d   = '0;
            end
            START: if (tx_clk) tx_state_d = DATA;
            DATA: if (tx_clk) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = STOP;
            end
            default: if (tx_clk) tx_state_d = IDLE;
        endcase
    end

    // The detecting tick resets the tick count, so the start bit is sampled
    // 8 ticks later (mid-bit) and every later bit 16 ticks after that.
    always_comb begin
        rx_cnt_d   = rx_clk ? '0 : rx_cnt_q + RXW'(1);
        rx_sync_d  = {rx_sync_q[0], rx};
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q & ~rx_ready_clear;
        if (rx_clk) begin
            rx_tick_d = rx_tick_q + 4'd1;
            case (rx_state_q)
                IDLE: begin
                    rx_tick_d = '0;
                    if (!rx_line) rx_state_d = START;
                end
                START: if (rx_tick_q == 4'd7) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_line ? IDLE : DATA;
                end
                DATA: if (rx_tick_q == 4'd15) begin
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                end
                default: if (rx_tick_q == 4'd15) begin
                    rx_state_d = IDLE;
                    if (rx_line) begin
                        rx_data_d  = rx_shift_q;
                        rx_ready_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_sync_q  <= 2'b11;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sync_q  <= rx_sync_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end
endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
// tb_uart_core: self-checking bench for uart_core at TX_DIV=32, RX_DIV=2.
module tb_uart_core;
    logic       sys_clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0, rx_drv = 1'b1, loop = 1'b0, rx_ready_clear = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_clk, rx_clk, tx, tx_busy, rx_ready, rx_in;
    logic [7:0] rx_data;
    int         errors = 0, checks = 0, cyc = 0;
    logic [7:0] sb[$];
    int         starts[$];

    typedef struct {
        logic       clr;
        logic [7:0] d;
        logic       stop;
        logic       exp_rdy;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vt[6];

    assign rx_in = loop ? tx : rx_drv;

    uart_core #(.CLK_FREQ(3_200_000), .BAUD(100_000)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .tx_clk(tx_clk), .rx_clk(rx_clk),
        .tx_en(tx_en), .tx_data(tx_data), .tx(tx), .tx_busy(tx_busy),
        .rx(rx_in), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ready_clear(rx_ready_clear)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_tx(input logic [7:0] d);
        tx_en = 1'b1;
        tx_data = d;
        sb.push_back(d);
        @(negedge sys_clk);
        tx_en = 1'b0;
    endtask

    task automatic pulse_clr();
        rx_ready_clear = 1'b1;
        @(negedge sys_clk);
        rx_ready_clear = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        rx_drv = 1'b0;
        tick(32);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(32);
        end
        rx_drv = stop;
        tick(32);
        rx_drv = 1'b1;
    endtask

    // Line monitor: decodes every frame on tx at mid-bit and pops the scoreboard.
    initial begin : mon
        logic       prev, ab;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (rst_n && prev && tx === 1'b0) begin
                starts.push_back(cyc);
                ab = 1'b0;
                b = 8'h00;
                repeat (15) begin @(negedge sys_clk); if (!rst_n) ab = 1'b1; end
                if (!ab) check("mon_start_bit", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (32) begin @(negedge sys_clk); if (!rst_n) ab = 1'b1; end
                    b[i] = tx;
                end
                repeat (32) begin @(negedge sys_clk); if (!rst_n) ab = 1'b1; end
                if (!ab) begin
                    check("mon_stop_bit", tx, 1'b1);
                    check("mon_frame_expected", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) check("mon_byte", b, sb.pop_front());
                end
            end
            prev = tx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rc, tc, pairs, busy_cnt, n0, k;
        int good[10];
        logic p, found;
        logic [9:0] a5f;
        vt[0] = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A};
        vt[1] = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h5A};
        vt[2] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
        vt[4] = '{1'b1, 8'h81, 1'b0, 1'b0, 8'h00};
        vt[5] = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01};
        a5f = {1'b1, 8'hA5, 1'b0};

        repeat (10) begin
            @(negedge sys_clk);
            tx_en = 1'($urandom_range(0, 1));
            tx_data = 8'($urandom);
            rx_drv = 1'($urandom_range(0, 1));
            rx_ready_clear = 1'($urandom_range(0, 1));
        end
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_ready", rx_ready, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_tx_clk", tx_clk, 1'b0);
        check("rst_rx_clk", rx_clk, 1'b0);
        tx_en = 1'b0; tx_data = 8'h00; rx_drv = 1'b1; rx_ready_clear = 1'b0;
        rst_n = 1'b1;
        rc = 0; tc = 0; pairs = 0; p = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge sys_clk);
            rc += int'(rx_clk);
            tc += int'(tx_clk);
            if (p && rx_clk) pairs++;
            p = rx_clk;
        end
        check("rx_clk_count", rc, 32);
        check("rx_clk_adjacent", pairs, 0);
        check("tx_clk_count", tc, 2);

        pulse_tx(8'hA5);
        @(negedge sys_clk);
        busy_cnt = 0;
        for (int b = 0; b < 10; b++) good[b] = 0;
        for (int i = 0; i < 340; i++) begin
            busy_cnt += int'(tx_busy);
            if (i < 320 && tx === a5f[i/32]) good[i/32]++;
            @(negedge sys_clk);
        end
        for (int b = 0; b < 10; b++) check($sformatf("a5_bit%0d_held", b), good[b], 32);
        check("a5_busy_cycles", busy_cnt, 320);

        loop = 1'b1;
        pulse_tx(8'h3C);
        for (k = 0; k < 500 && !rx_ready; k++) @(negedge sys_clk);
        check("lb_ready", rx_ready, 1'b1);
        check("lb_data", rx_data, 8'h3C);
        pulse_clr();
        check("clr_ready", rx_ready, 1'b0);
        check("clr_data", rx_data, 8'h3C);
        for (k = 0; k < 100 && tx_busy; k++) @(negedge sys_clk);
        tick(5);
        loop = 1'b0;

        rx_drv = 1'b0;
        tick(6);
        rx_drv = 1'b1;
        tick(400);
        check("false_start_ready", rx_ready, 1'b0);
        check("false_start_data", rx_data, 8'h3C);

        for (int i = 0; i < 6; i++) begin
            if (vt[i].clr) pulse_clr();
            send_rx(vt[i].d, vt[i].stop);
            tick(20);
            check($sformatf("vec%0d_ready", i), rx_ready, vt[i].exp_rdy);
            check($sformatf("vec%0d_data", i), rx_data, vt[i].exp_d);
        end

        pulse_clr();
        send_rx(8'h11, 1'b1);
        tick(20);
        check("ovr_first_ready", rx_ready, 1'b1);
        check("ovr_first_data", rx_data, 8'h11);
        rx_drv = 1'b0;
        tick(32);
        for (int i = 0; i < 8; i++) begin
            rx_drv = 1'(8'h22 >> i);
            tick(32);
        end
        check("ovr_pre_ready", rx_ready, 1'b1);
        check("ovr_pre_data", rx_data, 8'h11);
        rx_drv = 1'b1;
        rx_ready_clear = 1'b1;
        found = 1'b0;
        for (k = 0; k < 64 && !found; k++) begin
            @(negedge sys_clk);
            if (rx_data == 8'h22) found = 1'b1;
        end
        check("prio_set_wins", rx_ready, 1'b1);
        rx_ready_clear = 1'b0;
        @(negedge sys_clk);
        check("ovr_ready", rx_ready, 1'b1);
        check("ovr_data", rx_data, 8'h22);
        tick(40);

        check("sb_drained", sb.size(), 0);
        n0 = starts.size();
        tx_en = 1'b1;
        tx_data = 8'h01;
        sb.push_back(8'h01);
        @(negedge sys_clk);
        tx_data = 8'h80;
        for (k = 0; k < 800 && starts.size() < n0 + 2; k++) @(negedge sys_clk);
        tx_en = 1'b0;
        check("b2b_two_starts", starts.size() >= n0 + 2, 1'b1);
        if (starts.size() >= n0 + 2) check("b2b_period", starts[n0+1] - starts[n0], 321);
        tick(100);
        check("b2b_busy_mid", tx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        tick(3);
        rst_n = 1'b1;
        sb.delete();
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
